// File: rtl/weight_pkg.sv
// Shared constants and record type for the weight collector and its FIFO.
package weight_pkg;

  localparam int BYTES_PER_REC = 4;
  localparam int SUM_W         = 16;
  localparam int DIFF_W        = 17;
  // Widest row-block index a record can carry; the top narrows it to BLK_W.
  localparam int BLK_MAX_W     = 8;

  typedef struct packed {
    logic [SUM_W-1:0]     left;
    logic [SUM_W-1:0]     right;
    logic [DIFF_W-1:0]    diff;
    logic [BLK_MAX_W-1:0] blk;
  } rec_t;

  // Signed left-right difference of two unsigned block sums, one extra bit wide.
  function automatic logic [DIFF_W-1:0] sum_diff(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/weight_fifo.sv
// Synchronous record FIFO on dclk. A push into a full FIFO is accepted when a
// pop happens on the same edge. The head reads as zero while empty.
module weight_fifo
  import weight_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic dclk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  rec_t          mem_q [FIFO_DEPTH];
  rec_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/weight_collector.sv
// Reassembles 4-byte coder bursts into left/right block-sum records, tags each
// with a row-block index and buffers them behind a valid/ready output.
module weight_collector
  import weight_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BLK_W      = 4
) (
  input  logic              dclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_left,
  output logic [SUM_W-1:0]  out_right,
  output logic [DIFF_W-1:0] out_diff,
  output logic [BLK_W-1:0]  out_blk,
  output logic              overflow,
  output logic              frag_err
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_REC - 1);

  logic             ready_q, ready_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [BLK_W-1:0] blk_idx_q, blk_idx_d;
  logic [23:0]      shift_q, shift_d;
  logic             overflow_q, overflow_d;
  logic             frag_err_q, frag_err_d;
  logic             rec_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  rec_t             new_rec;
  rec_t             head;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // The byte3 capture completes the record: bytes 0-2 come from the shift
  // register, byte3 straight from in_byte.
  assign new_rec.left  = shift_q[23:8];
  assign new_rec.right = {shift_q[7:0], in_byte};
  assign new_rec.diff  = sum_diff(new_rec.left, new_rec.right);
  assign new_rec.blk   = BLK_MAX_W'(blk_idx_q);

  // Capture sequencing, fragment detection and sticky flags; frame_start wins.
  always_comb begin
    ready_d    = in_ready;
    byte_cnt_d = byte_cnt_q;
    blk_idx_d  = blk_idx_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    frag_err_d = frag_err_q;
    rec_push   = 1'b0;
    if (frame_start) begin
      byte_cnt_d = '0;
      blk_idx_d  = '0;
      overflow_d = 1'b0;
      frag_err_d = 1'b0;
    end else if (ready_q) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], in_byte};
      if (byte_cnt_q == LAST_BYTE) begin
        rec_push  = 1'b1;
        // The index advances even when the record is dropped.
        blk_idx_d = blk_idx_q + BLK_W'(1);
        if (fifo_full && !pop) begin
          overflow_d = 1'b1;
        end
      end
    end else if (byte_cnt_q != '0) begin
      frag_err_d = 1'b1;
      byte_cnt_d = '0;
    end
  end

  // Collector state registers.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      byte_cnt_q <= '0;
      blk_idx_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
      frag_err_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      byte_cnt_q <= byte_cnt_d;
      blk_idx_q  <= blk_idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      frag_err_q <= frag_err_d;
    end
  end

  weight_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .dclk  (dclk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (rec_push),
    .pop   (pop),
    .wdata (new_rec),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_left  = head.left;
  assign out_right = head.right;
  assign out_diff  = head.diff;
  assign out_blk   = head.blk[BLK_W-1:0];
  assign overflow  = overflow_q;
  assign frag_err  = frag_err_q;

  // Record blk bits above BLK_W are always zero.
  logic unused_blk;
  generate
    if (BLK_W < BLK_MAX_W) begin : g_blk_pad
      assign unused_blk = ^head.blk[BLK_MAX_W-1:BLK_W];
    end else begin : g_blk_full
      assign unused_blk = 1'b0;
    end
  endgenerate

endmodule

// File: doc/weight_collector.md
Name: weight_collector

Overview:
- Downstream consumer of the weight coder's serial output. The coder emits each block pair as 4 bytes on `dclk`, qualified by its `ready` line.
- This block reassembles the 4 bytes into left/right 16-bit block sums. It computes the signed left−right difference and tags the record with a row-block index within the frame.
- Records are buffered in a small FIFO and presented on a valid/ready interface to the next stage (weight decision / host readout).

Parameters:
- FIFO_DEPTH, 4, number of buffered records; power of two, ≥2.
- BLK_W, 4, width of the row-block index; wraps modulo 2^BLK_W.

Ports:
- dclk  in  1  byte clock; the same clock that drives the coder's output stage.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse, synchronous to dclk, at frame begin (vsync derived).
- in_ready  in  1  upstream "ready" (byte stream active).
- in_byte  in  8  upstream data byte.
- out_valid  out  1  record available at FIFO head.
- out_ready  in  1  consumer accepts head record when out_valid && out_ready.
- out_left  out  16  left block sum.
- out_right  out  16  right block sum.
- out_diff  out  17  signed left − right, two's complement.
- out_blk  out  BLK_W  row-block index of the record.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- frag_err  out  1  sticky: a byte stream ended with 1–3 bytes.

Behaviour:
- Reset (async, rst_n=0) clears everything. Outputs: out_valid=0, overflow=0, frag_err=0, out_left/right/diff/blk=0.
- Internal state cleared on reset:
  - FIFO pointers and count; byte_cnt=0; blk_idx=0.
  - ready_q=0; the shift register.
- Capture rule:
  - ready_q <= in_ready on every dclk edge.
  - A byte is captured on an edge where ready_q==1 (the byte on in_byte was loaded by upstream on the previous edge).
  - A 4-byte burst therefore yields exactly 4 captures.
- Byte order, MSB first:
  - byte0 = left[15:8], byte1 = left[7:0];
  - byte2 = right[15:8], byte3 = right[7:0].
- byte_cnt (2 bits) increments per capture and wraps 3→0. The capture of byte3 completes a record.
- Record push happens on the same edge as the byte3 capture:
  - The FIFO entry is written from shift-register bytes 0–2 plus in_byte.
  - out_diff = {1'b0,left} − {1'b0,right}, 17-bit.
  - out_blk = blk_idx; blk_idx then increments, wrapping modulo 2^BLK_W.
- Latency: out_valid is high after the byte3-capture edge when the FIFO was empty. There is no combinational bypass.
- Output handshake:
  - Head fields are held stable while out_valid && !out_ready.
  - The pop occurs on an edge with out_valid && out_ready.
- FIFO full when a record completes:
  - With no pop on the same edge: the record is dropped, overflow <= 1, and blk_idx still increments.
  - With a pop on the same edge: the push succeeds and there is no overflow.
- FIFO empty: a pop is impossible (out_valid=0); a push proceeds normally.
- Fragment: if ready_q==0 with byte_cnt∈{1,2,3}, then frag_err <= 1 and byte_cnt <= 0. The partial data is discarded and no push occurs.
- frame_start (synchronous, highest priority over capture on that edge) clears:
  - byte_cnt and blk_idx;
  - overflow and frag_err;
  - the FIFO (flush).
  - out_valid=0 on the next cycle.
- Reset asserted mid-burst: immediate clear. The bytes that follow are treated as a new burst only after ready_q sees a fresh assertion sequence. No special resync logic: byte_cnt restarts at 0.

Decomposition:
- Shared package weight_pkg:
  - constants BYTES_PER_REC=4, SUM_W=16, DIFF_W=17;
  - a record struct type {left, right, diff, blk}.
- One natural sub-module: weight_fifo, a synchronous FIFO on dclk with rst_n.
  - Parameter: FIFO_DEPTH.
  - Interfaces: push/pop, full/empty.
  - Write-when-full-with-pop is allowed.

Test Plan:
- Single burst: after reset, drive in_ready for 4 cycles with bytes 00,1B,00,36, and hold out_ready=1. Required response:
  - one record left=27, right=54, diff=0x1FFE5 (−27), blk=0;
  - out_valid high for exactly one cycle after the 4th capture edge.
- Backpressure/full: out_ready=0 and 5 bursts with FIFO_DEPTH=4 (left=1..5, right=0). Required response:
  - 4 records held in order, blk 0..3; overflow=1 after the 5th burst.
  - Then out_ready=1 pops left=1,2,3,4 on consecutive cycles.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the byte3-capture edge. Required response: overflow stays 0; the new record appears last.
- Fragment: in_ready high for 2 cycles (bytes 12,34), then low, then a full burst 00,05,00,03. Required response: frag_err=1 and exactly one record left=5, right=3, diff=2.
- Frame restart: 3 records pushed (blk 0..2), then frame_start. Required response:
  - out_valid=0, flags cleared;
  - the next burst yields blk=0.
- Async reset mid-burst: rst_n low after byte1, released, then a full burst 00,07,00,07. Required response: one record with diff=0, blk=0, frag_err=0.
